// File: rtl/tug_light_field.sv
// Tug-of-war playfield driver: moves a single light along LEDR[9:1]
// according to player button presses. It also supplies the edge-light
// levels and the accepted-press pulses used by the win-detection block.
// Same-cycle presses cancel, a post-move lockout ignores new presses,
// and Freeze holds the whole playfield once the game is over.
module tug_light_field #(
    parameter int unsigned LOCKOUT = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       L,
    input  logic       R,
    input  logic       Freeze,
    output logic [8:0] LEDR,
    output logic       LPulse,
    output logic       RPulse,
    output logic       LED9,
    output logic       LED1,
    output logic       dbg_state   // 1 = LOCKED, 0 = IDLE
);

    // The counter is at least one bit wide, so LOCKOUT = 0 still elaborates.
    localparam int CW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
    localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCKOUT);
    localparam logic [8:0]    CENTRE    = 9'b000010000;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_q,  state_d;
    logic [8:0]    ledr_q,   ledr_d;
    logic          lpulse_q, lpulse_d;
    logic          rpulse_q, rpulse_d;
    logic          l_d_q,    l_d_d;
    logic          r_d_q,    r_d_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic lrise;
    logic rrise;
    logic can_accept;
    logic acc_l;
    logic acc_r;

    // Edge detection, acceptance and next light position / lockout count.
    always_comb begin
        // Button history follows the inputs every cycle, even while frozen
        // or locked out, so a button held across either never reads as a press.
        l_d_d = L;
        r_d_d = R;

        lrise = L & ~l_d_q;
        rrise = R & ~r_d_q;

        can_accept = ~Freeze & (cnt_q == '0);
        // Rises on both sides in the same cycle cancel each other.
        acc_l = can_accept & lrise & ~rrise;
        acc_r = can_accept & rrise & ~lrise;

        ledr_d   = ledr_q;
        lpulse_d = 1'b0;
        rpulse_d = 1'b0;
        cnt_d    = cnt_q;

        if (Freeze) begin
            // Game over: light and counter hold; pulses stay low.
            ledr_d = ledr_q;
            cnt_d  = cnt_q;
        end else if (acc_l) begin
            // Saturate at LED9; the win block decides what reaching it means.
            ledr_d   = ledr_q[8] ? ledr_q : (ledr_q << 1);
            lpulse_d = 1'b1;
            cnt_d    = LOCK_LOAD;
        end else if (acc_r) begin
            ledr_d   = ledr_q[0] ? ledr_q : (ledr_q >> 1);
            rpulse_d = 1'b1;
            cnt_d    = LOCK_LOAD;
        end else if (cnt_q != '0) begin
            // Rises seen while counting down are dropped, not queued.
            cnt_d = cnt_q - CW'(1);
        end

        state_d = (cnt_d != '0) ? LOCKED : IDLE;
    end

    // State, light, pulse and history registers; reset recentres the light.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            ledr_q   <= CENTRE;
            lpulse_q <= 1'b0;
            rpulse_q <= 1'b0;
            l_d_q    <= 1'b0;
            r_d_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ledr_q   <= ledr_d;
            lpulse_q <= lpulse_d;
            rpulse_q <= rpulse_d;
            l_d_q    <= l_d_d;
            r_d_q    <= r_d_d;
            cnt_q    <= cnt_d;
        end
    end

    assign LEDR      = ledr_q;
    assign LPulse    = lpulse_q;
    assign RPulse    = rpulse_q;
    assign LED9      = ledr_q[8];
    assign LED1      = ledr_q[0];
    assign dbg_state = (state_q == LOCKED);

    // The light must never vanish or split.
    always @(posedge Clock) begin
        if (!Reset) begin
            assert ($onehot(ledr_q))
            else $error("LEDR not one-hot: %b", ledr_q);
        end
    end

endmodule

// File: tb/tb_tug_light_field.sv
// Bench for tug_light_field (LOCKOUT = 4). Directed vectors push the
// expected post-edge outputs into a queue; a monitor pops and compares
// one entry after every rising clock edge.
module tb_tug_light_field;

  localparam logic [8:0] P1 = 9'b000000001;
  localparam logic [8:0] P2 = 9'b000000010;
  localparam logic [8:0] P3 = 9'b000000100;
  localparam logic [8:0] P4 = 9'b000001000;
  localparam logic [8:0] P5 = 9'b000010000;
  localparam logic [8:0] P6 = 9'b000100000;
  localparam logic [8:0] P7 = 9'b001000000;
  localparam logic [8:0] P8 = 9'b010000000;
  localparam logic [8:0] P9 = 9'b100000000;

  logic       clock;
  logic       reset;
  logic       l_in;
  logic       r_in;
  logic       freeze;
  logic [8:0] ledr;
  logic       lpulse;
  logic       rpulse;
  logic       led9;
  logic       led1;
  logic       dbg_state;

  // expected = {locked, LEDR, LPulse, RPulse, LED9, LED1}
  logic [13:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          errors;

  tug_light_field #(.LOCKOUT(4)) dut (
    .Clock     (clock),
    .Reset     (reset),
    .L         (l_in),
    .R         (r_in),
    .Freeze    (freeze),
    .LEDR      (ledr),
    .LPulse    (lpulse),
    .RPulse    (rpulse),
    .LED9      (led9),
    .LED1      (led1),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    reset  = 1'b1;
    l_in   = 1'b0;
    r_in   = 1'b0;
    freeze = 1'b0;
  end

  // driver: one clock cycle of inputs plus the expected outputs after its edge
  task automatic cyc(input string nm, input logic l, input logic r,
                     input logic f, input logic rst, input logic [8:0] el,
                     input logic elp, input logic erp, input logic elk);
    @(negedge clock);
    l_in   = l;
    r_in   = r;
    freeze = f;
    reset  = rst;
    exp_q.push_back({elk, el, elp, erp, el[8], el[0]});
    name_q.push_back(nm);
  endtask

  // accepted press followed by the four-cycle lockout draining to idle
  task automatic press_l(input string nm, input logic [8:0] np);
    cyc(nm, 1, 0, 0, 0, np, 1, 0, 1);
    cyc(nm, 0, 0, 0, 0, np, 0, 0, 1);
    cyc(nm, 0, 0, 0, 0, np, 0, 0, 1);
    cyc(nm, 0, 0, 0, 0, np, 0, 0, 1);
    cyc(nm, 0, 0, 0, 0, np, 0, 0, 0);
  endtask

  task automatic press_r(input string nm, input logic [8:0] np);
    cyc(nm, 0, 1, 0, 0, np, 0, 1, 1);
    cyc(nm, 0, 0, 0, 0, np, 0, 0, 1);
    cyc(nm, 0, 0, 0, 0, np, 0, 0, 1);
    cyc(nm, 0, 0, 0, 0, np, 0, 0, 1);
    cyc(nm, 0, 0, 0, 0, np, 0, 0, 0);
  endtask

  // scoreboard monitor
  always @(posedge clock) begin
    logic [13:0] e;
    logic [13:0] a;
    string       n;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {dbg_state, ledr, lpulse, rpulse, led9, led1};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got lk/ledr/lp/rp/l9/l1=%b required %b", n, a, e);
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    // reset, buttons low
    for (int i = 0; i < 4; i++) cyc("reset", 0, 0, 0, 1, P5, 0, 0, 0);

    // L held for 10 cycles: one move, one pulse
    cyc("hold_first", 1, 0, 0, 0, P6, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc("hold_lock", 1, 0, 0, 0, P6, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc("hold_idle", 1, 0, 0, 0, P6, 0, 0, 0);
    cyc("hold_release", 0, 0, 0, 0, P6, 0, 0, 0);

    // lockout: L, R at +2 ignored, R at +6 accepted
    cyc("lo_reset", 0, 0, 0, 1, P5, 0, 0, 0);
    cyc("lo_reset", 0, 0, 0, 1, P5, 0, 0, 0);
    cyc("lo_l", 1, 0, 0, 0, P6, 1, 0, 1);
    cyc("lo_1", 0, 0, 0, 0, P6, 0, 0, 1);
    cyc("lo_r_ignored", 0, 1, 0, 0, P6, 0, 0, 1);
    cyc("lo_3", 0, 0, 0, 0, P6, 0, 0, 1);
    cyc("lo_4", 0, 0, 0, 0, P6, 0, 0, 0);
    cyc("lo_5", 0, 0, 0, 0, P6, 0, 0, 0);
    cyc("lo_r_accepted", 0, 1, 0, 0, P5, 0, 1, 1);
    cyc("lo_7", 0, 0, 0, 0, P5, 0, 0, 1);
    cyc("lo_8", 0, 0, 0, 0, P5, 0, 0, 1);
    cyc("lo_9", 0, 0, 0, 0, P5, 0, 0, 1);
    cyc("lo_10", 0, 0, 0, 0, P5, 0, 0, 0);

    // simultaneous rise cancels; next single press goes straight through
    cyc("both_cancel", 1, 1, 0, 0, P5, 0, 0, 0);
    cyc("both_release", 0, 0, 0, 0, P5, 0, 0, 0);
    press_l("after_cancel", P6);

    // walk to LED9 from centre, then saturate
    cyc("sat_reset", 0, 0, 0, 1, P5, 0, 0, 0);
    press_l("walk_l6", P6);
    press_l("walk_l7", P7);
    press_l("walk_l8", P8);
    press_l("walk_l9", P9);
    cyc("sat_l", 1, 0, 0, 0, P9, 1, 0, 1);

    // freeze during lockout: counter holds, presses ignored, held R on thaw not a press
    cyc("frz_lock", 0, 0, 1, 0, P9, 0, 0, 1);
    cyc("frz_lock_r", 0, 1, 1, 0, P9, 0, 0, 1);
    cyc("frz_lock_hold", 0, 1, 1, 0, P9, 0, 0, 1);
    cyc("thaw_held_r", 0, 1, 0, 0, P9, 0, 0, 1);
    cyc("thaw_2", 0, 0, 0, 0, P9, 0, 0, 1);
    cyc("thaw_1", 0, 0, 0, 0, P9, 0, 0, 1);
    cyc("thaw_0", 0, 0, 0, 0, P9, 0, 0, 0);

    // freeze while idle: R press ignored
    cyc("frz_idle", 0, 0, 1, 0, P9, 0, 0, 0);
    cyc("frz_idle_r", 0, 1, 1, 0, P9, 0, 0, 0);
    cyc("frz_idle_rel", 0, 0, 1, 0, P9, 0, 0, 0);
    cyc("frz_off", 0, 0, 0, 0, P9, 0, 0, 0);

    // walk right to LED1, then saturate
    press_r("walk_r8", P8);
    press_r("walk_r7", P7);
    press_r("walk_r6", P6);
    press_r("walk_r5", P5);
    press_r("walk_r4", P4);
    press_r("walk_r3", P3);
    press_r("walk_r2", P2);
    press_r("walk_r1", P1);
    cyc("sat_r", 0, 1, 0, 0, P1, 0, 1, 1);

    // reset mid-pulse / mid-lockout, then immediate L press
    cyc("rst_mid", 0, 0, 0, 1, P5, 0, 0, 0);
    cyc("rst_then_l", 1, 0, 0, 0, P6, 1, 0, 1);
    cyc("rst_after_1", 0, 0, 0, 0, P6, 0, 0, 1);

    // drain and confirm every expectation was consumed
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tug_light_field.md
Name: tug_light_field

Overview:
- Playfield driver for the tug-of-war game: converts player button presses into a single moving light on LEDR[9:1].
- Supplies the edge-light levels (LED9, LED1) and the press pulses consumed by the win-detection block.
- One lit LED at all times. A left press moves it toward LED9; a right press moves it toward LED1.
- Includes press edge detection, simultaneous-press cancellation, a post-move lockout counter and a freeze input for game over.

Parameters:
- LOCKOUT, default 4: cycles after an accepted move during which new presses are ignored. 0 disables the lockout.

Ports:
- Clock  input  1  system clock
- Reset  input  1  synchronous, active-high; returns light to centre
- L  input  1  left player button level (already synchronised, active-high)
- R  input  1  right player button level (already synchronised, active-high)
- Freeze  input  1  game over; while high, light and lockout hold and no presses are accepted
- LEDR  output  9  one-hot light position; bit 8 = LED9 (leftmost), bit 0 = LED1 (rightmost)
- LPulse  output  1  one-cycle registered pulse: accepted left press
- RPulse  output  1  one-cycle registered pulse: accepted right press
- LED9  output  1  equals LEDR[8]
- LED1  output  1  equals LEDR[0]

Behaviour:
- Reset (sync, active-high, dominates everything):
  - LEDR = 9'b000010000 (centre, LED5); LPulse = RPulse = 0.
  - Lockout counter = 0; edge-detect history registers = 0, so a button held through reset must be released before it counts.
- Edge detect:
  - Lrise = L & ~L_d; Rrise = R & ~R_d.
  - L_d and R_d update every cycle, including while frozen or locked out.
- Acceptance: a rise is accepted only when Freeze = 0 and the lockout counter = 0.
- Simultaneous events:
  - Lrise and Rrise in the same cycle cancel: no move, no pulse, lockout not started.
  - Single-sided rise accepted: LPulse or RPulse goes high the next cycle for exactly one cycle. Same edge: LEDR shifts one position (L: left shift, toward bit 8; R: right shift, toward bit 0).
- Edge saturation:
  - Accepted L with LEDR[8] = 1: light stays at bit 8, LPulse still fires.
  - Accepted R with LEDR[0] = 1: light stays at bit 0, RPulse still fires.
  - The win block detects LED9&L / LED1&R; this block never wraps.
- Latency: button rising edge at cycle n -> LEDR and pulse change at the clock edge ending cycle n (registered outputs, visible cycle n+1).
- Lockout:
  - Each accepted press loads the counter with LOCKOUT; the counter decrements each non-frozen cycle to 0.
  - Rises during lockout are discarded permanently, not queued.
- Freeze:
  - Outputs hold; LPulse/RPulse forced 0; counter holds.
  - Deasserting Freeze does not generate a press from a button held throughout.
- State machine: IDLE (counter = 0, accepting) / LOCKED (counter > 0).
  - IDLE -> LOCKED on an accepted press when LOCKOUT > 0.
  - LOCKED -> IDLE when the counter reaches 0.
  - Freeze holds the current state.
- Invariant: LEDR is always exactly one-hot; $onehot(LEDR) is asserted every cycle after reset.
- Reset mid-lockout or mid-pulse: next cycle shows the centre light, pulses 0, state IDLE.

Test Plan:
- Reset 4 cycles, buttons low -> LEDR = 000010000, LED9 = LED1 = 0, pulses 0.
- L held high for 10 cycles after reset -> exactly one move to 000100000, one LPulse cycle; holding does not repeat.
- LOCKOUT = 4: L pulse, R pulse 2 cycles later, R again 6 cycles after the first -> R at +2 ignored, R at +6 accepted; light returns to 000010000; one RPulse total.
- L and R rising in the same cycle -> LEDR unchanged, no pulses, next single press accepted immediately.
- Four separated L presses to reach 100000000 (LED9 = 1), then one more L press -> LEDR stays 100000000, LPulse fires. Freeze = 1 then R press -> no change, no pulse.
- Reset asserted one cycle after an accepted R press during lockout -> LEDR = 000010000, counter 0; an immediate L rise after reset is accepted.
